// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and Gray helpers for the async FIFO pointer blocks
package async_fifo_pkg;

  localparam int AW_MIN = 2;

  // Callers zero-extend into 32 bits and cast the result back to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary conversion (XOR prefix from the MSB down)
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// rtl/rptr_empty_lvl.sv - async FIFO read pointer, empty/almost-empty flags, level and underflow
module rptr_empty_lvl
  import async_fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic [AW:0]   rq2_wptr,
  input  logic          pop,
  input  logic          rflush,
  input  logic [AW:0]   rae_thresh,
  input  logic          rerr_clr,
  output logic [AW:0]   rptr,
  output logic [AW-1:0] raddr,
  output logic          rempty,
  output logic          ralmost_empty,
  output logic [AW:0]   rlevel,
  output logic          runderflow
);

  generate
    if (AW < AW_MIN) begin : g_aw_check
      $error("rptr_empty_lvl: AW must be at least AW_MIN");
    end
  endgenerate

  logic [AW:0] rbin;
  logic [AW:0] wbin;
  logic [AW:0] rbin_next;
  logic [AW:0] rgray_next;
  logic [AW:0] level_next;
  logic        pop_ok;
  logic        underflow_set;

  gray2bin #(.W(AW + 1)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign pop_ok        = pop & ~rempty & ~rflush;
  assign underflow_set = pop & rempty & ~rflush;

  // A flush discards everything by jumping straight to the synchronised write pointer.
  assign rbin_next  = rflush ? wbin : rbin + {{AW{1'b0}}, pop_ok};
  assign rgray_next = (AW + 1)'(bin2gray(32'(rbin_next)));
  assign level_next = wbin - rbin_next;

  assign raddr = rbin[AW-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= rae_thresh);
      if (underflow_set) begin
        runderflow <= 1'b1;
      end else if (rerr_clr) begin
        runderflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb/tb_rptr_empty_lvl.sv - scoreboard bench for rptr_empty_lvl with directed vectors (AW=4)
module tb_rptr_empty_lvl;

  localparam int AW = 4;

  typedef struct {
    string          name;
    logic [AW:0]    rptr;
    logic [AW-1:0]  raddr;
    logic           rempty;
    logic [AW:0]    rlevel;
    logic           rae;
    logic           ruf;
  } exp_t;

  logic          rclk;
  logic          rrst;
  logic [AW:0]   rq2_wptr;
  logic          pop;
  logic          rflush;
  logic [AW:0]   rae_thresh;
  logic          rerr_clr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;
  logic          runderflow;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  rptr_empty_lvl #(.AW(AW)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rq2_wptr      (rq2_wptr),
    .pop           (pop),
    .rflush        (rflush),
    .rae_thresh    (rae_thresh),
    .rerr_clr      (rerr_clr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string nm, input int act, input int exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: every falling edge, the oldest expectation is compared against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge rclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".rptr"},          int'(rptr),          int'(e.rptr));
        check({e.name, ".raddr"},         int'(raddr),         int'(e.raddr));
        check({e.name, ".rempty"},        int'(rempty),        int'(e.rempty));
        check({e.name, ".rlevel"},        int'(rlevel),        int'(e.rlevel));
        check({e.name, ".ralmost_empty"}, int'(ralmost_empty), int'(e.rae));
        check({e.name, ".runderflow"},    int'(runderflow),    int'(e.ruf));
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic [AW:0] wp,
                      input logic p, input logic fl, input logic [AW:0] th, input logic clr,
                      input logic [AW:0] e_rptr, input logic [AW-1:0] e_raddr,
                      input logic e_empty, input logic [AW:0] e_lvl, input logic e_ae,
                      input logic e_uf);
    exp_t e;
    @(negedge rclk);
    #1;
    rrst       = rst;
    rq2_wptr   = wp;
    pop        = p;
    rflush     = fl;
    rae_thresh = th;
    rerr_clr   = clr;
    e.name   = nm;
    e.rptr   = e_rptr;
    e.raddr  = e_raddr;
    e.rempty = e_empty;
    e.rlevel = e_lvl;
    e.rae    = e_ae;
    e.ruf    = e_uf;
    exp_q.push_back(e);
  endtask

  initial begin
    rrst = 1'b1; rq2_wptr = '0; pop = 1'b0; rflush = 1'b0; rae_thresh = 5'd2; rerr_clr = 1'b0;

    //    name        rst wptr      pop fl thr    clr  rptr      raddr e  lvl    ae uf
    step("rst0",      1, 5'b00000, 1, 0, 5'd2, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("rst1",      1, 5'b00000, 1, 0, 5'd2, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("rel",       0, 5'b00000, 0, 0, 5'd2, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("w5",        0, 5'b00111, 0, 0, 5'd2, 0,  5'b00000, 4'd0, 0, 5'd5,  0, 0);
    step("pop1",      0, 5'b00111, 1, 0, 5'd2, 0,  5'b00001, 4'd1, 0, 5'd4,  0, 0);
    step("pop2",      0, 5'b00111, 1, 0, 5'd2, 0,  5'b00011, 4'd2, 0, 5'd3,  0, 0);
    step("pop3",      0, 5'b00111, 1, 0, 5'd2, 0,  5'b00010, 4'd3, 0, 5'd2,  1, 0);
    step("pop4",      0, 5'b00111, 1, 0, 5'd2, 0,  5'b00110, 4'd4, 0, 5'd1,  1, 0);
    step("pop5",      0, 5'b00111, 1, 0, 5'd2, 0,  5'b00111, 4'd5, 1, 5'd0,  1, 0);
    step("uflow",     0, 5'b00111, 1, 0, 5'd2, 0,  5'b00111, 4'd5, 1, 5'd0,  1, 1);
    step("uf_hold",   0, 5'b00111, 0, 0, 5'd2, 0,  5'b00111, 4'd5, 1, 5'd0,  1, 1);
    step("uf_setwin", 0, 5'b00111, 1, 0, 5'd2, 1,  5'b00111, 4'd5, 1, 5'd0,  1, 1);
    step("uf_clr",    0, 5'b00111, 0, 0, 5'd2, 1,  5'b00111, 4'd5, 1, 5'd0,  1, 0);
    step("fl_to4",    0, 5'b00110, 0, 1, 5'd2, 0,  5'b00110, 4'd4, 1, 5'd0,  1, 0);
    step("w9",        0, 5'b01101, 0, 0, 5'd2, 0,  5'b00110, 4'd4, 0, 5'd5,  0, 0);
    step("fl_pop",    0, 5'b01101, 1, 1, 5'd2, 0,  5'b01101, 4'd9, 1, 5'd0,  1, 0);
    step("fl_to0",    0, 5'b00000, 0, 1, 5'd2, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("full16",    0, 5'b11000, 0, 0, 5'd2, 0,  5'b00000, 4'd0, 0, 5'd16, 0, 0);
    step("fl_to31",   0, 5'b10000, 0, 1, 5'd2, 0,  5'b10000, 4'd15, 1, 5'd0, 1, 0);
    step("w0_wrap",   0, 5'b00000, 0, 0, 5'd2, 0,  5'b10000, 4'd15, 0, 5'd1, 1, 0);
    step("pop_wrap",  0, 5'b00000, 1, 0, 5'd2, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("th0_w1",    0, 5'b00001, 0, 0, 5'd0, 0,  5'b00000, 4'd0, 0, 5'd1,  0, 0);
    step("th0_pop",   0, 5'b00001, 1, 0, 5'd0, 0,  5'b00001, 4'd1, 1, 5'd0,  1, 0);
    step("w3",        0, 5'b00010, 0, 0, 5'd0, 0,  5'b00001, 4'd1, 0, 5'd2,  0, 0);
    step("rst_mid",   1, 5'b00010, 1, 1, 5'd0, 0,  5'b00000, 4'd0, 1, 5'd0,  1, 0);
    step("post_rst",  0, 5'b00010, 0, 0, 5'd0, 0,  5'b00000, 4'd0, 0, 5'd3,  0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge rclk);
      #2;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rptr_empty_lvl.md
RPTR_EMPTY_LVL -- requirements
Module: rptr_empty_lvl

Interface
REQ-001 SHALL have parameter AW, default 4, address width (FIFO depth 2^AW, legal AW >= 2).
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rq2_wptr  input  AW+1  write pointer, Gray-coded, already synchronised into rclk.
REQ-005 SHALL have port pop  input  1  read request.
REQ-006 SHALL have port rflush  input  1  discard all stored words (read pointer jumps to write pointer).
REQ-007 SHALL have port rae_thresh  input  AW+1  almost-empty threshold, binary word count.
REQ-008 SHALL have port rerr_clr  input  1  clears the sticky underflow flag.
REQ-009 SHALL have port rptr  output  AW+1  registered Gray read pointer, to the write domain.
REQ-010 SHALL have port raddr  output  AW  RAM read address = rbin[AW-1:0].
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port ralmost_empty  output  1  registered, level <= rae_thresh.
REQ-013 SHALL have port rlevel  output  AW+1  registered occupancy 0..2^AW, as seen by the read side.
REQ-014 SHALL have port runderflow  output  1  sticky, pop attempted while empty.

Function
REQ-015 Internal binary read counter rbin (AW+1 bits); wbin = Gray-to-binary(rq2_wptr), combinational.
REQ-016 pop_ok = pop & !rempty & !rflush.
REQ-017 rbin_next = wbin when rflush, else rbin + pop_ok, modulo 2^(AW+1) (natural wrap 2^(AW+1)-1 -> 0).
REQ-018 rgray_next = (rbin_next >> 1) ^ rbin_next; rptr <= rgray_next each edge.
REQ-019 rempty <= (rgray_next == rq2_wptr); one-edge latency, no combinational path to rempty.
REQ-020 level_next = (wbin - rbin_next) modulo 2^(AW+1); rlevel <= level_next.
REQ-021 ralmost_empty <= (level_next <= rae_thresh); rae_thresh = 0 makes it track rempty.
REQ-022 runderflow set on edge where pop & rempty & !rflush; rbin/rptr unchanged by that pop.
REQ-023 runderflow cleared when rerr_clr, unless set condition occurs same edge (set wins).
REQ-024 rflush has priority over pop; pop coincident with rflush is ignored, never flags underflow.
REQ-025 rempty, rlevel, ralmost_empty are pessimistic (write-side updates arrive via rq2_wptr only); no false non-empty.

Reset
REQ-026 rrst high at an edge SHALL override all other inputs at that edge, including mid-pop or mid-flush.
REQ-027 Reset values: rbin 0, rptr 0, raddr 0, rempty 1, rlevel 0, ralmost_empty 1, runderflow 0.

Structure
REQ-028 Shared package async_fifo_pkg SHALL hold the bin2gray function and constant AW_MIN = 2; no per-instance typedefs.
REQ-029 One sub-module gray2bin (parameter W, combinational XOR-prefix) SHALL perform the wbin conversion.
REQ-030 AW < AW_MIN SHALL be rejected at elaboration.

Verification (AW=4)
REQ-031 rrst high 2 cycles with pop=1 -> after release: rempty=1, rptr=0, rlevel=0, ralmost_empty=1, runderflow=0.
REQ-032 rq2_wptr=gray(5)=5'b00111, rae_thresh=2 -> next edge rempty=0, rlevel=5, ralmost_empty=0; then 3 pops -> rlevel=2, raddr=3, ralmost_empty=1.
REQ-033 rbin=0, rq2_wptr=gray(16)=5'b11000 -> rlevel=16, rempty=0; rbin=31, wptr=gray(0), pop -> rbin=0, rptr=0, raddr=0, rempty=1.
REQ-034 pop=1 while rempty=1 -> rptr unchanged, runderflow=1 next edge, held until rerr_clr pulse -> 0.
REQ-035 rbin=4, rq2_wptr=gray(9)=5'b01101, rflush=1 and pop=1 same edge -> rbin=9, raddr=9, rempty=1, rlevel=0, runderflow=0.
